// File: rtl/yc_enc_pkg.sv
// Shared constants for the Y/C encoder: colour-matrix coefficients, subcarrier
// phase encoding and DAC code bound helpers.
package yc_enc_pkg;

  localparam int C_YR = 77;
  localparam int C_YG = 150;
  localparam int C_YB = 29;
  localparam int C_U  = 144;
  localparam int C_V  = 183;

  // Subcarrier quarter-phases: which chroma component is emitted, and its sign
  typedef enum logic [1:0] {
    PH_PU = 2'd0,
    PH_PV = 2'd1,
    PH_NU = 2'd2,
    PH_NV = 2'd3
  } ph_t;

  function automatic int code_max(input int out_w);
    return (1 << out_w) - 1;
  endfunction

  function automatic int code_mid(input int out_w);
    return 1 << (out_w - 1);
  endfunction

endpackage

// File: rtl/yc_matrix.sv
// Two-register RGB -> {Ys, U, V} colour matrix: input register, then the
// registered luma sum and scaled colour-difference terms.
module yc_matrix
  import yc_enc_pkg::*;
#(
  parameter int RGB_W = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [RGB_W-1:0]        r,
  input  logic [RGB_W-1:0]        g,
  input  logic [RGB_W-1:0]        b,
  output logic [RGB_W+7:0]        ys_p2,
  output logic signed [RGB_W:0]   u_p2,
  output logic signed [RGB_W:0]   v_p2
);

  localparam int YW = RGB_W + 8;
  localparam int DW = RGB_W + 1;
  localparam int PW = RGB_W + 11;

  logic [RGB_W-1:0]     r_p1, g_p1, b_p1;
  logic [YW-1:0]        ys;
  logic [RGB_W-1:0]     yc;
  logic signed [DW-1:0] du, dv, u_nxt, v_nxt;

  // Stage 1: input register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1 <= '0;
      g_p1 <= '0;
      b_p1 <= '0;
    end else begin
      r_p1 <= r;
      g_p1 <= g;
      b_p1 <= b;
    end
  end

  always_comb begin
    ys    = YW'(r_p1) * YW'(C_YR) + YW'(g_p1) * YW'(C_YG) + YW'(b_p1) * YW'(C_YB);
    yc    = ys[YW-1:8];
    du    = $signed({1'b0, b_p1}) - $signed({1'b0, yc});
    dv    = $signed({1'b0, r_p1}) - $signed({1'b0, yc});
    u_nxt = DW'((PW'(du) * PW'(C_U)) >>> 8);
    v_nxt = DW'((PW'(dv) * PW'(C_V)) >>> 8);
  end

  // Stage 2: matrix result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ys_p2 <= '0;
      u_p2  <= '0;
      v_p2  <= '0;
    end else begin
      ys_p2 <= ys;
      u_p2  <= u_nxt;
      v_p2  <= v_nxt;
    end
  end

endmodule

// File: rtl/yc_encoder.sv
// RGB + syncs to S-video Y/C DAC codes: free-running 4x fsc phase, PAL V-switch,
// burst window counter and a three-stage pipeline to the output registers.
module yc_encoder
  import yc_enc_pkg::*;
#(
  parameter int RGB_W       = 1,
  parameter int OUT_W       = 4,
  parameter int BLANK_LVL   = 5,
  parameter int BURST_AMP   = 2,
  parameter int BURST_START = 4,
  parameter int BURST_LEN   = 10
) (
  input  logic             I_CLK,
  input  logic             I_RST_N,
  input  logic             I_SC_EN,
  input  logic             I_PAL,
  input  logic [RGB_W-1:0] I_R,
  input  logic [RGB_W-1:0] I_G,
  input  logic [RGB_W-1:0] I_B,
  input  logic             I_DISP,
  input  logic             I_HSYNC,
  input  logic             I_VSYNC,
  output logic [OUT_W-1:0] O_Y,
  output logic [OUT_W-1:0] O_C,
  output logic             O_PAL_SW
);

  localparam int YW    = RGB_W + 8;
  localparam int PW    = YW + OUT_W + 1;
  localparam int CW    = OUT_W + 2;
  localparam int CMAX  = code_max(OUT_W);
  localparam int MID   = code_mid(OUT_W);
  localparam int SHIFT = OUT_W - 1 - RGB_W;

  localparam logic [OUT_W-1:0] C_MID   = OUT_W'(MID);
  localparam logic [OUT_W-1:0] C_BLO   = OUT_W'(MID - BURST_AMP);
  localparam logic [OUT_W-1:0] C_BHI   = OUT_W'(MID + BURST_AMP);
  localparam logic [OUT_W-1:0] C_BLANK = OUT_W'(BLANK_LVL);
  localparam logic [5:0]       BCNT_MAX = 6'd63;

  function automatic logic [OUT_W-1:0] sat_y(input logic [PW-1:0] v);
    logic [PW-1:0] s;
    s = v + PW'(BLANK_LVL);
    if (s > PW'(CMAX)) return OUT_W'(CMAX);
    return OUT_W'(s);
  endfunction

  function automatic logic [OUT_W-1:0] sat_c(input logic signed [CW-1:0] v);
    if (v < 0) return '0;
    if (v > CW'(CMAX)) return OUT_W'(CMAX);
    return OUT_W'(v);
  endfunction

  ph_t        ph;
  logic       sw, hs_d;
  logic [5:0] bcnt;
  logic       csync, burst;

  assign csync    = I_HSYNC ^ I_VSYNC;
  assign burst    = !csync && (int'(bcnt) >= BURST_START) &&
                    (int'(bcnt) < BURST_START + BURST_LEN);
  assign O_PAL_SW = sw;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      ph   <= PH_PU;
      sw   <= 1'b0;
      hs_d <= 1'b0;
      bcnt <= BCNT_MAX;
    end else begin
      if (I_SC_EN) ph <= ph_t'(ph + 2'd1);
      hs_d <= I_HSYNC;
      if (!I_PAL) sw <= 1'b0;
      else if (I_HSYNC && !hs_d) sw <= ~sw;
      if (I_HSYNC) bcnt <= '0;
      else if (I_SC_EN && bcnt != BCNT_MAX) bcnt <= bcnt + 6'd1;
    end
  end

  logic [RGB_W+7:0]   ys_p2;
  logic signed [RGB_W:0] u_p2, v_p2;

  yc_matrix #(.RGB_W(RGB_W)) u_matrix (
    .clk   (I_CLK),
    .rst_n (I_RST_N),
    .r     (I_R),
    .g     (I_G),
    .b     (I_B),
    .ys_p2 (ys_p2),
    .u_p2  (u_p2),
    .v_p2  (v_p2)
  );

  logic csync_p1, disp_p1, burst_p1, sw_p1, pal_p1;
  logic csync_p2, disp_p2, burst_p2, sw_p2, pal_p2;
  ph_t  ph_p1, ph_p2;

  // Stage 1 / stage 2: decode flags travel alongside the matrix data
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      csync_p1 <= 1'b0; disp_p1 <= 1'b0; burst_p1 <= 1'b0;
      sw_p1    <= 1'b0; pal_p1  <= 1'b0; ph_p1    <= PH_PU;
      csync_p2 <= 1'b0; disp_p2 <= 1'b0; burst_p2 <= 1'b0;
      sw_p2    <= 1'b0; pal_p2  <= 1'b0; ph_p2    <= PH_PU;
    end else begin
      csync_p1 <= csync;    disp_p1 <= I_DISP;  burst_p1 <= burst;
      sw_p1    <= sw;       pal_p1  <= I_PAL;   ph_p1    <= ph;
      csync_p2 <= csync_p1; disp_p2 <= disp_p1; burst_p2 <= burst_p1;
      sw_p2    <= sw_p1;    pal_p2  <= pal_p1;  ph_p2    <= ph_p1;
    end
  end

  logic [PW-1:0]        y_prod;
  logic signed [CW-1:0] u_ext, v_ext, smp;
  logic [OUT_W-1:0]     y_code, c_code;

  always_comb begin
    y_prod = PW'(ys_p2) * PW'(CMAX - BLANK_LVL);
    u_ext  = CW'(u_p2);
    v_ext  = sw_p2 ? -CW'(v_p2) : CW'(v_p2);
    case (ph_p2)
      PH_PU:   smp = u_ext;
      PH_PV:   smp = v_ext;
      PH_NU:   smp = -u_ext;
      default: smp = -v_ext;
    endcase

    if (csync_p2)     y_code = '0;
    else if (!disp_p2) y_code = C_BLANK;
    else               y_code = sat_y(y_prod >> YW);

    // PAL burst swings +/-135 degrees: the V-axis half follows the line switch
    if (burst_p2) begin
      case (ph_p2)
        PH_PU:   c_code = C_BLO;
        PH_NU:   c_code = C_BHI;
        PH_PV:   c_code = !pal_p2 ? C_MID : (sw_p2 ? C_BLO : C_BHI);
        default: c_code = !pal_p2 ? C_MID : (sw_p2 ? C_BHI : C_BLO);
      endcase
    end else if (csync_p2 || !disp_p2) begin
      c_code = C_MID;
    end else begin
      c_code = sat_c((smp <<< SHIFT) + CW'(MID));
    end
  end

  // Stage 3: output register
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_Y <= C_BLANK;
      O_C <= C_MID;
    end else begin
      O_Y <= y_code;
      O_C <= c_code;
    end
  end

endmodule

// File: tb/tb_yc_encoder.sv
// Bench for yc_encoder: a default instance and a wide instance share control
// inputs and are compared cycle-exact against an arithmetic reference model.
module tb_yc_encoder;

  logic clk;
  logic rst_n, sc_en, pal, disp, hs, vs;
  logic [0:0] r0, g0, b0;
  logic [3:0] r1, g1, b1;
  logic [3:0] y0, c0;
  logic [7:0] y1, c1;
  logic sw0, sw1;

  int checks = 0;
  int errors = 0;

  int m_ph, m_sw, m_hsd, m_bcnt;
  int py0[3], pc0[3], py1[3], pc1[3];

  yc_encoder u0 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_SC_EN(sc_en), .I_PAL(pal),
    .I_R(r0), .I_G(g0), .I_B(b0), .I_DISP(disp), .I_HSYNC(hs), .I_VSYNC(vs),
    .O_Y(y0), .O_C(c0), .O_PAL_SW(sw0)
  );

  yc_encoder #(.RGB_W(4), .OUT_W(8), .BLANK_LVL(40), .BURST_AMP(20),
               .BURST_START(4), .BURST_LEN(10)) u1 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_SC_EN(sc_en), .I_PAL(pal),
    .I_R(r1), .I_G(g1), .I_B(b1), .I_DISP(disp), .I_HSYNC(hs), .I_VSYNC(vs),
    .O_Y(y1), .O_C(c1), .O_PAL_SW(sw1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: output codes for the current inputs and model state
  function automatic void model_codes(input int rw, input int ow, input int blank,
                                      input int amp, input int r, input int g,
                                      input int b, output int y, output int c);
    int mid, cmax, ys, yc, u, v, vp, s, csync;
    bit burst;
    mid   = 1 << (ow - 1);
    cmax  = (1 << ow) - 1;
    csync = int'(hs ^ vs);
    burst = (csync == 0) && (m_bcnt >= 4) && (m_bcnt < 14);
    ys    = 77 * r + 150 * g + 29 * b;
    yc    = ys / 256;
    u     = ((b - yc) * 144) >>> 8;
    v     = ((r - yc) * 183) >>> 8;
    vp    = (m_sw != 0) ? -v : v;
    if (csync != 0) y = 0;
    else if (!disp) y = blank;
    else begin
      y = blank + (ys * (cmax - blank)) / (1 << (rw + 8));
      if (y > cmax) y = cmax;
    end
    if (burst) begin
      case (m_ph)
        0:       c = mid - amp;
        2:       c = mid + amp;
        1:       c = !pal ? mid : ((m_sw != 0) ? mid - amp : mid + amp);
        default: c = !pal ? mid : ((m_sw != 0) ? mid + amp : mid - amp);
      endcase
    end else if (csync != 0 || !disp) begin
      c = mid;
    end else begin
      case (m_ph)
        0:       s = u;
        1:       s = vp;
        2:       s = -u;
        default: s = -vp;
      endcase
      c = mid + s * (1 << (ow - 1 - rw));
      if (c < 0) c = 0;
      if (c > cmax) c = cmax;
    end
  endfunction

  task automatic model_reset();
    m_ph = 0; m_sw = 0; m_hsd = 0; m_bcnt = 63;
    for (int i = 0; i < 3; i++) begin
      py0[i] = 5; pc0[i] = 8; py1[i] = 40; pc1[i] = 128;
    end
  endtask

  // One clock: model evaluates, DUT clocks, both advance; returns at posedge+1
  task automatic tick();
    int ey0, ec0, ey1, ec1;
    model_codes(1, 4, 5, 2, int'(r0), int'(g0), int'(b0), ey0, ec0);
    model_codes(4, 8, 40, 20, int'(r1), int'(g1), int'(b1), ey1, ec1);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!pal) m_sw = 0;
      else if (hs && m_hsd == 0) m_sw = 1 - m_sw;
      m_hsd = int'(hs);
      if (hs) m_bcnt = 0;
      else if (sc_en && m_bcnt < 63) m_bcnt++;
      if (sc_en) m_ph = (m_ph + 1) % 4;
      for (int i = 2; i > 0; i--) begin
        py0[i] = py0[i-1]; pc0[i] = pc0[i-1]; py1[i] = py1[i-1]; pc1[i] = pc1[i-1];
      end
      py0[0] = ey0; pc0[0] = ec0; py1[0] = ey1; pc1[0] = ec1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sc_en = 1'b0; pal = 1'b0; disp = 1'b0; hs = 1'b0; vs = 1'b0;
    r0 = '0; g0 = '0; b0 = '0; r1 = '0; g1 = '0; b1 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks += 5;
      if (y0 !== 4'd5)   begin errors++; $display("FAIL reset_y0 cyc=%0d got=%0d exp=5", i, y0); end
      if (c0 !== 4'd8)   begin errors++; $display("FAIL reset_c0 cyc=%0d got=%0d exp=8", i, c0); end
      if (sw0 !== 1'b0)  begin errors++; $display("FAIL reset_sw cyc=%0d got=%0b exp=0", i, sw0); end
      if (y1 !== 8'd40)  begin errors++; $display("FAIL reset_y1 cyc=%0d got=%0d exp=40", i, y1); end
      if (c1 !== 8'd128) begin errors++; $display("FAIL reset_c1 cyc=%0d got=%0d exp=128", i, c1); end
      tick();
    end
  endtask

  task automatic test_white();
    disp = 1'b1; sc_en = 1'b1; hs = 1'b0; vs = 1'b0;
    r0 = 1'b1; g0 = 1'b1; b0 = 1'b1; r1 = 4'hf; g1 = 4'hf; b1 = 4'hf;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks += 2;
      if (y0 !== 4'(py0[2])) begin errors++; $display("FAIL white_y0 cyc=%0d got=%0d exp=%0d", i, y0, py0[2]); end
      if (y1 !== 8'(py1[2])) begin errors++; $display("FAIL white_y1 cyc=%0d got=%0d exp=%0d", i, y1, py1[2]); end
      if (i >= 3) begin
        checks += 2;
        if (c0 !== 4'd8)   begin errors++; $display("FAIL white_c0 cyc=%0d got=%0d exp=8", i, c0); end
        if (c1 !== 8'd128) begin errors++; $display("FAIL white_c1 cyc=%0d got=%0d exp=128", i, c1); end
      end
    end
  endtask

  task automatic test_blue();
    r0 = 1'b0; g0 = 1'b0; b0 = 1'b1; r1 = 4'h0; g1 = 4'h0; b1 = 4'hf;
    for (int i = 0; i < 12; i++) begin
      sc_en = (i % 3 != 2);
      tick();
      checks += 4;
      if (y0 !== 4'(py0[2])) begin errors++; $display("FAIL blue_y0 cyc=%0d got=%0d exp=%0d", i, y0, py0[2]); end
      if (c0 !== 4'(pc0[2])) begin errors++; $display("FAIL blue_c0 cyc=%0d got=%0d exp=%0d", i, c0, pc0[2]); end
      if (y1 !== 8'(py1[2])) begin errors++; $display("FAIL blue_y1 cyc=%0d got=%0d exp=%0d", i, y1, py1[2]); end
      if (c1 !== 8'(pc1[2])) begin errors++; $display("FAIL blue_c1 cyc=%0d got=%0d exp=%0d", i, c1, pc1[2]); end
    end
  endtask

  task automatic test_burst_ntsc();
    int n_lo, n_hi, n_other;
    n_lo = 0; n_hi = 0; n_other = 0;
    pal = 1'b0; disp = 1'b0; vs = 1'b0; sc_en = 1'b1;
    hs = 1'b1;
    repeat (2) tick();
    hs = 1'b0;
    for (int i = 0; i < 23; i++) begin
      tick();
      checks += 2;
      if (c0 !== 4'(pc0[2])) begin errors++; $display("FAIL burst_c0 cyc=%0d got=%0d exp=%0d", i, c0, pc0[2]); end
      if (c1 !== 8'(pc1[2])) begin errors++; $display("FAIL burst_c1 cyc=%0d got=%0d exp=%0d", i, c1, pc1[2]); end
      if (c0 == 4'd6) n_lo++;
      else if (c0 == 4'd10) n_hi++;
      else if (c0 != 4'd8) n_other++;
    end
    checks += 3;
    if (n_lo != 5 - n_hi) begin errors++; $display("FAIL burst_count got=%0d exp=5", n_lo + n_hi); end
    if (n_hi < 2 || n_hi > 3) begin errors++; $display("FAIL burst_hi_count got=%0d exp=2..3", n_hi); end
    if (n_other != 0) begin errors++; $display("FAIL burst_codes got=%0d stray codes exp=0", n_other); end
  endtask

  task automatic test_pal_lines();
    pal = 1'b0; hs = 1'b0; vs = 1'b0; disp = 1'b0; sc_en = 1'b1;
    tick();
    pal = 1'b1;
    for (int line = 0; line < 2; line++) begin
      hs = 1'b1;
      tick();
      checks++;
      if (sw0 !== ((line == 0) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL pal_sw line=%0d got=%0b exp=%0b", line, sw0, (line == 0));
      end
      hs = 1'b0;
      for (int i = 0; i < 30; i++) begin
        disp = (i >= 16);
        r1 = 4'($urandom_range(0, 15)); g1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15));
        tick();
        checks += 4;
        if (c0 !== 4'(pc0[2])) begin errors++; $display("FAIL pal_c0 line=%0d cyc=%0d got=%0d exp=%0d", line, i, c0, pc0[2]); end
        if (c1 !== 8'(pc1[2])) begin errors++; $display("FAIL pal_c1 line=%0d cyc=%0d got=%0d exp=%0d", line, i, c1, pc1[2]); end
        if (y1 !== 8'(py1[2])) begin errors++; $display("FAIL pal_y1 line=%0d cyc=%0d got=%0d exp=%0d", line, i, y1, py1[2]); end
        if (sw1 !== 1'(m_sw))  begin errors++; $display("FAIL pal_sw1 line=%0d cyc=%0d got=%0b exp=%0d", line, i, sw1, m_sw); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sc_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) pal = ~pal;
      hs   = ($urandom_range(0, 19) == 0);
      vs   = ($urandom_range(0, 59) == 0);
      disp = ($urandom_range(0, 3) != 0);
      r0 = 1'($urandom_range(0, 1)); g0 = 1'($urandom_range(0, 1)); b0 = 1'($urandom_range(0, 1));
      r1 = 4'($urandom_range(0, 15)); g1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15));
      tick();
      checks += 5;
      if (y0 !== 4'(py0[2])) begin errors++; $display("FAIL rand_y0 cyc=%0d got=%0d exp=%0d", i, y0, py0[2]); end
      if (c0 !== 4'(pc0[2])) begin errors++; $display("FAIL rand_c0 cyc=%0d got=%0d exp=%0d", i, c0, pc0[2]); end
      if (y1 !== 8'(py1[2])) begin errors++; $display("FAIL rand_y1 cyc=%0d got=%0d exp=%0d", i, y1, py1[2]); end
      if (c1 !== 8'(pc1[2])) begin errors++; $display("FAIL rand_c1 cyc=%0d got=%0d exp=%0d", i, c1, pc1[2]); end
      if (sw0 !== 1'(m_sw))  begin errors++; $display("FAIL rand_sw cyc=%0d got=%0b exp=%0d", i, sw0, m_sw); end
    end
  endtask

  task automatic test_reset_mid();
    pal = 1'b1; vs = 1'b0; disp = 1'b0; sc_en = 1'b1;
    hs = 1'b1;
    tick();
    hs = 1'b0;
    repeat (9) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (y0 !== 4'd5)   begin errors++; $display("FAIL midrst_y0 got=%0d exp=5", y0); end
    if (c0 !== 4'd8)   begin errors++; $display("FAIL midrst_c0 got=%0d exp=8", c0); end
    if (sw0 !== 1'b0)  begin errors++; $display("FAIL midrst_sw got=%0b exp=0", sw0); end
    if (y1 !== 8'd40)  begin errors++; $display("FAIL midrst_y1 got=%0d exp=40", y1); end
    if (c1 !== 8'd128) begin errors++; $display("FAIL midrst_c1 got=%0d exp=128", c1); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks += 2;
      if (c0 !== 4'd8)   begin errors++; $display("FAIL postrst_c0 cyc=%0d got=%0d exp=8", i, c0); end
      if (c1 !== 8'(pc1[2])) begin errors++; $display("FAIL postrst_c1 cyc=%0d got=%0d exp=%0d", i, c1, pc1[2]); end
    end
  endtask

  initial begin
    test_reset();
    test_white();
    test_blue();
    test_burst_ntsc();
    test_pal_lines();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
